// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM states,
// parity mode constants and the bit-period calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  function automatic int unsigned bit_cnt_max(input int unsigned clk_freq,
                                              input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter with a mid-bit sample pulse; clr_i
// realigns the period to a detected start edge.
module uart_baud_tick #(
  parameter int unsigned CNT_MAX = 434
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else if (clr_i || (cnt_q == CW'(CNT_MAX - 1))) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == CW'(CNT_MAX / 2 - 1));

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable width, parity and stop bits, delivering
// words over a valid/ready port with parity, framing and overrun flags.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] po_data,
  output logic                 po_valid,
  input  logic                 po_ready,
  output logic                 po_par_err,
  output logic                 po_frm_err,
  output logic                 po_ovr_err,
  output logic                 busy
);

  localparam int unsigned BIT_CNT_MAX = bit_cnt_max(CLK_FREQ, BAUD);
  localparam logic [2:0]  LAST_DATA   = 3'(DATA_BITS - 1);
  localparam logic [2:0]  LAST_STOP   = 3'(STOP_BITS - 1);
  localparam logic        PAR_TARGET  = (PARITY == PAR_ODD);

  logic rx_s1_q, rx_s2_q, rx_s3_q;
  logic fall, tick, baud_clr;

  uart_state_e          state_q, state_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 frm_q, frm_d;
  logic                 done_q, done_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  assign fall = rx_s3_q & ~rx_s2_q;

  uart_baud_tick #(
    .CNT_MAX(BIT_CNT_MAX)
  ) u_baud (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .clr_i    (baud_clr),
    .tick_o   (tick)
  );

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    frm_d    = frm_q;
    done_d   = 1'b0;
    baud_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d  = ST_START;
          baud_clr = 1'b1;
          bit_d    = '0;
          par_d    = 1'b0;
          frm_d    = 1'b0;
        end
      end
      ST_START: begin
        if (tick) state_d = rx_s2_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = {rx_s2_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          par_d   = ((^shift_q) ^ rx_s2_q) != PAR_TARGET;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (!rx_s2_q) frm_d = 1'b1;
          // Leave at the final stop sample so a start edge in its second half is seen.
          if (bit_q == LAST_STOP) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      frm_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      frm_q   <= frm_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      po_data    <= '0;
      po_valid   <= 1'b0;
      po_par_err <= 1'b0;
      po_frm_err <= 1'b0;
      po_ovr_err <= 1'b0;
    end else begin
      if (done_q && (!po_valid || po_ready)) begin
        po_data    <= shift_q;
        po_par_err <= par_q;
        po_frm_err <= frm_q;
        po_valid   <= 1'b1;
      end else if (po_valid && po_ready) begin
        po_valid <= 1'b0;
      end
      if (done_q && po_valid && !po_ready) begin
        po_ovr_err <= 1'b1;
      end else if (po_valid && po_ready) begin
        po_ovr_err <= 1'b0;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench: a default 8N1 receiver and a fast 8E2 receiver, each
// checked against a frame-level reference model by a dedicated monitor.
module tb_uart_rx_cfg;

  localparam int BA = 50_000_000 / 115200;
  localparam int BB = 10;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  always #5 sys_clk = ~sys_clk;

  logic       rx_a, ready_a, valid_a, perr_a, ferr_a, oerr_a, busy_a;
  logic [7:0] data_a;
  logic       rx_b, ready_b, valid_b, perr_b, ferr_b, oerr_b, busy_b;
  logic [7:0] data_b;

  uart_rx_cfg dut_a (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx        (rx_a),
    .po_data   (data_a),
    .po_valid  (valid_a),
    .po_ready  (ready_a),
    .po_par_err(perr_a),
    .po_frm_err(ferr_a),
    .po_ovr_err(oerr_a),
    .busy      (busy_a)
  );

  uart_rx_cfg #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000),
    .DATA_BITS(8),
    .PARITY   (2),
    .STOP_BITS(2)
  ) dut_b (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx        (rx_b),
    .po_data   (data_b),
    .po_valid  (valid_b),
    .po_ready  (ready_b),
    .po_par_err(perr_b),
    .po_frm_err(ferr_b),
    .po_ovr_err(oerr_b),
    .busy      (busy_b)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int errors = 0;
  int checks = 0;
  int got_a = 0;
  int run_a = 0;
  int max_run_a = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: even parity over data+parity bit, framing if any stop bit is 0.
  function automatic exp_t model(input logic [7:0] d, input logic pbit, input logic use_par,
                                 input logic [1:0] stops, input int nstop);
    exp_t e;
    e.d  = d;
    e.pe = use_par && ((($countones(d) + int'(pbit)) % 2) != 0);
    e.fe = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
    return e;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input bit to_b, input logic v);
    if (to_b) rx_b = v;
    else      rx_a = v;
  endtask

  task automatic send(input bit to_b, input logic [7:0] d, input logic pbit, input logic [1:0] stops);
    int bl;
    int ns;
    bl = to_b ? BB : BA;
    ns = to_b ? 2 : 1;
    drive(to_b, 1'b0);
    wait_cyc(bl);
    for (int i = 0; i < 8; i++) begin
      drive(to_b, d[i]);
      wait_cyc(bl);
    end
    if (to_b) begin
      drive(to_b, pbit);
      wait_cyc(bl);
    end
    for (int i = 0; i < ns; i++) begin
      drive(to_b, stops[i]);
      wait_cyc(bl);
    end
    drive(to_b, 1'b1);
    wait_cyc(2 * bl);
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (sys_rst_n && valid_a) run_a++;
    else run_a = 0;
    if (run_a > max_run_a) max_run_a = run_a;
    if (sys_rst_n && valid_a && ready_a) begin
      got_a++;
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_a_unexpected: got word %0h expected none", data_a);
      end else begin
        e = q_a.pop_front();
        check("mon_a_data", 32'(data_a), 32'(e.d));
        check("mon_a_par", 32'(perr_a), 32'(e.pe));
        check("mon_a_frm", 32'(ferr_a), 32'(e.fe));
      end
    end
  end

  logic       pv_b = 1'b0, pr_b = 1'b0, pp_b = 1'b0, pf_b = 1'b0;
  logic [7:0] pd_b = '0;

  always @(negedge sys_clk) begin
    exp_t e;
    if (sys_rst_n && pv_b && !pr_b && valid_b)
      check("b_hold_stable", 32'({data_b, perr_b, ferr_b}), 32'({pd_b, pp_b, pf_b}));
    if (sys_rst_n && valid_b && ready_b) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_b_unexpected: got word %0h expected none", data_b);
      end else begin
        e = q_b.pop_front();
        check("mon_b_data", 32'(data_b), 32'(e.d));
        check("mon_b_par", 32'(perr_b), 32'(e.pe));
        check("mon_b_frm", 32'(ferr_b), 32'(e.fe));
      end
    end
    pv_b = valid_b; pr_b = ready_b; pd_b = data_b; pp_b = perr_b; pf_b = ferr_b;
  end

  initial begin
    logic [7:0] d;
    logic       p;
    logic [1:0] s;
    int         n0;
    rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    sys_rst_n = 1'b0;
    wait_cyc(5);
    check("rst_valid_a", 32'(valid_a), 0);
    check("rst_data_a", 32'(data_a), 0);
    check("rst_busy_a", 32'(busy_a), 0);
    check("rst_ovr_a", 32'(oerr_a), 0);
    check("rst_valid_b", 32'(valid_b), 0);
    sys_rst_n = 1'b1;
    wait_cyc(5);

    q_a.push_back(model(8'h55, 1'b0, 1'b0, 2'b11, 1));
    send(1'b0, 8'h55, 1'b0, 2'b11);

    q_b.push_back(model(8'hA5, 1'b1, 1'b1, 2'b11, 2));
    send(1'b1, 8'hA5, 1'b1, 2'b11);
    q_b.push_back(model(8'hA5, 1'b0, 1'b1, 2'b11, 2));
    send(1'b1, 8'hA5, 1'b0, 2'b11);
    q_b.push_back(model(8'h3C, 1'b0, 1'b1, 2'b01, 2));
    send(1'b1, 8'h3C, 1'b0, 2'b01);

    // Overrun: second frame arrives while the first is still held.
    ready_b = 1'b0;
    q_b.push_back(model(8'h11, 1'b0, 1'b1, 2'b11, 2));
    send(1'b1, 8'h11, 1'b0, 2'b11);
    send(1'b1, 8'h22, 1'b0, 2'b11);
    wait_cyc(3);
    check("ovr_held_data", 32'(data_b), 32'h11);
    check("ovr_flag_set", 32'(oerr_b), 1);
    check("ovr_valid_held", 32'(valid_b), 1);
    ready_b = 1'b1;
    wait_cyc(3);
    check("ovr_flag_clear", 32'(oerr_b), 0);
    check("ovr_valid_clear", 32'(valid_b), 0);

    for (int k = 0; k < 40; k++) begin
      d = 8'($urandom);
      p = (^d) ^ (($urandom % 4) == 0);
      s = {1'(($urandom % 6) != 0), 1'(($urandom % 6) != 0)};
      q_b.push_back(model(d, p, 1'b1, s, 2));
      send(1'b1, d, p, s);
    end

    // Glitch shorter than half a bit must be rejected.
    rx_a = 1'b0;
    wait_cyc(5);
    check("glitch_busy_rise", 32'(busy_a), 1);
    wait_cyc(95);
    rx_a = 1'b1;
    wait_cyc(BA / 2 + 6 - 100);
    check("glitch_busy_fall", 32'(busy_a), 0);
    wait_cyc(50);

    // Reset in data bit 4 of 0xF0, then a clean 0x0F.
    d = 8'hF0;
    drive(1'b0, 1'b0);
    wait_cyc(BA);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, d[i]);
      wait_cyc(BA);
    end
    drive(1'b0, d[4]);
    wait_cyc(BA / 2);
    sys_rst_n = 1'b0;
    wait_cyc(3);
    check("midrst_busy", 32'(busy_a), 0);
    check("midrst_valid", 32'(valid_a), 0);
    sys_rst_n = 1'b1;
    wait_cyc(BA);
    check("postrst_busy", 32'(busy_a), 0);
    n0 = got_a;
    q_a.push_back(model(8'h0F, 1'b0, 1'b0, 2'b11, 1));
    send(1'b0, 8'h0F, 1'b0, 2'b11);
    check("postrst_words", 32'(got_a - n0), 1);

    d = 8'($urandom);
    q_a.push_back(model(d, 1'b0, 1'b0, 2'b11, 1));
    send(1'b0, d, 1'b0, 2'b11);

    for (int t = 0; t < 200 && (q_a.size() != 0 || q_b.size() != 0); t++) wait_cyc(1);
    check("drain_a", 32'(q_a.size()), 0);
    check("drain_b", 32'(q_b.size()), 0);
    check("a_valid_pulse_width", 32'(max_run_a), 1);
    check("a_ovr_never", 32'(oerr_a), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
